truth_table_sequencer: RTL and testbench

- Self-checking stimulus controller for the lab's combinational equation blocks (SOP/POS/gate-level variants).
- Sweeps every input combination of an N_IN-input unit-under-test in ascending binary order, with the MSB as the first operand (A).
- Waits a programmable settle time, then samples the UUT outputs and compares them against a golden truth table.
- Reports per-vector results, error count, first failing index and pass/fail, replacing hand-written delay-based stimulus sequences.

---
 rtl/truth_table_sequencer.sv | 165 ++++++++++++++++
 tb/tb_truth_table_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: sweeps all 2^N_IN input vectors of a combinational
// unit-under-test. It holds each vector for SETTLE cycles, then samples the UUT
// outputs and checks them against a golden table. It reports per-vector
// results, the error count, the first failing index and pass/fail.
module truth_table_sequencer #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned N_OUT  = 1,
  parameter int unsigned SETTLE = 1,
  parameter logic [N_OUT*(2**N_IN)-1:0] GOLDEN = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  vec,
  input  logic [N_OUT-1:0] dut_out,
  output logic             busy,
  output logic             sample_valid,
  output logic             sample_ok,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count,
  output logic [N_IN-1:0]  first_err_idx,
  output logic             first_err_valid
);

  localparam int unsigned     NVec    = 2 ** N_IN;
  localparam int unsigned     CntW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LastVec = '1;

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [N_IN:0]    err_q, err_d;
  logic [N_IN-1:0]  first_idx_q, first_idx_d;
  logic             first_vld_q, first_vld_d;
  logic             sv_q, sv_d;
  logic             ok_q, ok_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [N_OUT-1:0] expected;
  logic             match;

  // Golden lookup for the current vector; constant slices keep the mux simple.
  always_comb begin
    expected = '0;
    for (int i = 0; i < NVec; i++) begin
      if (vec_q == N_IN'(i)) expected = GOLDEN[i*N_OUT +: N_OUT];
    end
  end

  assign match = (dut_out == expected);

  // Next-state and registered-output logic for the sweep FSM.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    first_idx_d = first_idx_q;
    first_vld_d = first_vld_q;
    pass_d      = pass_q;
    sv_d        = 1'b0;
    ok_d        = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // abort is ignored here, so start wins when both are high.
        if (start) begin
          vec_d       = '0;
          cnt_d       = '0;
          err_d       = '0;
          first_vld_d = 1'b0;
          pass_d      = 1'b0;
          state_d     = StSettle;
        end
      end
      StSettle: begin
        if (abort) begin
          state_d = StIdle;
          vec_d   = '0;
          pass_d  = 1'b0;
        end else if (cnt_q == CntLast) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSample: begin
        if (abort) begin
          // The sample of the aborting cycle is dropped entirely.
          state_d = StIdle;
          vec_d   = '0;
          pass_d  = 1'b0;
        end else begin
          sv_d = 1'b1;
          ok_d = match;
          if (!match) begin
            err_d = err_q + 1'b1;
            if (!first_vld_q) begin
              first_idx_d = vec_q;
              first_vld_d = 1'b1;
            end
          end
          if (vec_q == LastVec) begin
            state_d = StDone;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d   = vec_q + 1'b1;
            cnt_d   = '0;
            state_d = StSettle;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      vec_q       <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      first_idx_q <= '0;
      first_vld_q <= 1'b0;
      sv_q        <= 1'b0;
      ok_q        <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      first_idx_q <= first_idx_d;
      first_vld_q <= first_vld_d;
      sv_q        <= sv_d;
      ok_q        <= ok_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign vec             = vec_q;
  assign busy            = (state_q == StSettle) || (state_q == StSample);
  assign sample_valid    = sv_q;
  assign sample_ok       = ok_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_idx   = first_idx_q;
  assign first_err_valid = first_vld_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer. DUT a is a 3-input majority checker
// (SETTLE=1), and DUT b is a 2-input half-adder checker (SETTLE=3). The UUT
// models are behavioural functions with injectable per-vector faults. The
// expected cycle-by-cycle behaviour comes from sweep arithmetic.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sel = 1'b0;  // 0: DUT a, 1: DUT b
  logic rst_all = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [1:0] fault [8];

  logic       rst_n_a, rst_n_b, start_a, start_b, abort_a, abort_b;
  logic [2:0] vec_a, fidx_a;
  logic [3:0] err_a;
  logic [0:0] dut_out_a;
  logic       busy_a, sv_a, ok_a, done_a, pass_a, fv_a;
  logic [1:0] vec_b, fidx_b, dut_out_b;
  logic [2:0] err_b;
  logic       busy_b, sv_b, ok_b, done_b, pass_b, fv_b;

  assign rst_n_a = rst_all & (sel | rst_n);
  assign rst_n_b = rst_all & (~sel | rst_n);
  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign abort_a = abort & ~sel;
  assign abort_b = abort & sel;

  // Behavioural UUTs: majority and half adder {carry, sum}, XOR-ed with faults.
  always_comb begin
    dut_out_a = ($countones(vec_a) >= 2) ? 1'b1 : 1'b0;
    dut_out_a = dut_out_a ^ fault[vec_a][0];
    dut_out_b = {vec_b[1] & vec_b[0], vec_b[1] ^ vec_b[0]} ^ fault[vec_b];
  end

  truth_table_sequencer #(
    .N_IN(3), .N_OUT(1), .SETTLE(1), .GOLDEN(8'b1110_1000)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .abort(abort_a), .vec(vec_a),
    .dut_out(dut_out_a), .busy(busy_a), .sample_valid(sv_a), .sample_ok(ok_a),
    .done(done_a), .pass(pass_a), .err_count(err_a), .first_err_idx(fidx_a),
    .first_err_valid(fv_a)
  );

  truth_table_sequencer #(
    .N_IN(2), .N_OUT(2), .SETTLE(3), .GOLDEN(8'b10_01_01_00)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .abort(abort_b), .vec(vec_b),
    .dut_out(dut_out_b), .busy(busy_b), .sample_valid(sv_b), .sample_ok(ok_b),
    .done(done_b), .pass(pass_b), .err_count(err_b), .first_err_idx(fidx_b),
    .first_err_valid(fv_b)
  );

  logic [31:0] o_vec, o_err, o_fidx;
  logic        o_busy, o_sv, o_ok, o_done, o_pass, o_fv;

  always_comb begin
    o_vec  = sel ? 32'(vec_b)  : 32'(vec_a);
    o_err  = sel ? 32'(err_b)  : 32'(err_a);
    o_fidx = sel ? 32'(fidx_b) : 32'(fidx_a);
    o_busy = sel ? busy_b : busy_a;
    o_sv   = sel ? sv_b   : sv_a;
    o_ok   = sel ? ok_b   : ok_a;
    o_done = sel ? done_b : done_a;
    o_pass = sel ? pass_b : pass_a;
    o_fv   = sel ? fv_b   : fv_a;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t sel=%0d)", tag, got, exp, $time, sel);
    end
  endtask

  // Vector v's result becomes visible in cycle (v+1)*p+1 after the start edge.
  function automatic int errs_upto(int k, int p, int nv);
    int c = 0;
    for (int v = 0; v < nv; v++) if (fault[v] != 0 && (v + 1) * p + 1 <= k) c++;
    return c;
  endfunction

  function automatic int first_upto(int k, int p, int nv);
    for (int v = 0; v < nv; v++) if (fault[v] != 0 && (v + 1) * p + 1 <= k) return v;
    return -1;
  endfunction

  task automatic clear_faults();
    for (int v = 0; v < 8; v++) fault[v] = 2'd0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, " vec"}, o_vec, 0);
    check_eq({tag, " busy"}, 32'(o_busy), 0);
    check_eq({tag, " sample_valid"}, 32'(o_sv), 0);
    check_eq({tag, " sample_ok"}, 32'(o_ok), 0);
    check_eq({tag, " done"}, 32'(o_done), 0);
    check_eq({tag, " pass"}, 32'(o_pass), 0);
    check_eq({tag, " err_count"}, o_err, 0);
    check_eq({tag, " first_err_idx"}, o_fidx, 0);
    check_eq({tag, " first_err_valid"}, 32'(o_fv), 0);
  endtask

  // One sweep from a start pulse; abort_at/rst_at = 0 means none. Called at a negedge.
  task automatic run_sweep(input logic s, input int abort_at, input int rst_at,
                           input bit extra_starts, input bit abort_with_start);
    int n, st, p, nv, t, cut_k, errs, first;
    bit by_rst;
    sel = s;
    n = s ? 2 : 3;
    st = s ? 3 : 1;
    p = st + 1;
    nv = 1 << n;
    t = nv * p + 1;
    cut_k = 0;
    by_rst = 1'b0;
    start = 1'b1;
    abort = abort_with_start;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
      if (cut_k != 0) begin
        check_eq("cut busy", 32'(o_busy), 0);
        check_eq("cut done", 32'(o_done), 0);
        check_eq("cut sample_valid", 32'(o_sv), 0);
        check_eq("cut vec", o_vec, 0);
        check_eq("cut pass", 32'(o_pass), 0);
        if (k == cut_k + 1) begin
          errs = by_rst ? 0 : errs_upto(cut_k, p, nv);
          first = by_rst ? -1 : first_upto(cut_k, p, nv);
          check_eq("cut err_count", o_err, errs);
          check_eq("cut first_err_valid", 32'(o_fv), (first >= 0) ? 1 : 0);
          if (first >= 0) check_eq("cut first_err_idx", o_fidx, first);
          if (by_rst) check_eq("reset first_err_idx", o_fidx, 0);
        end
        if (k == cut_k + 2) break;
      end else begin
        errs = errs_upto(k, p, nv);
        first = first_upto(k, p, nv);
        check_eq("busy", 32'(o_busy), (k < t) ? 1 : 0);
        check_eq("done", 32'(o_done), (k == t) ? 1 : 0);
        check_eq("vec", o_vec, (k < t) ? (k - 1) / p : nv - 1);
        check_eq("sample_valid", 32'(o_sv), (k > p && k <= t && (k - 1) % p == 0) ? 1 : 0);
        if (k > p && k <= t && (k - 1) % p == 0)
          check_eq("sample_ok", 32'(o_ok), (fault[(k - 1) / p - 1] == 0) ? 1 : 0);
        check_eq("err_count", o_err, errs);
        check_eq("first_err_valid", 32'(o_fv), (first >= 0) ? 1 : 0);
        if (first >= 0) check_eq("first_err_idx", o_fidx, first);
        check_eq("pass", 32'(o_pass), (k >= t && errs == 0) ? 1 : 0);
        if (k == t + 1) break;
      end
      if (cut_k == 0) begin
        if (extra_starts && (k == 3 || k == 9)) start = 1'b1;
        if (k == abort_at) begin
          abort = 1'b1;
          cut_k = k;
        end
        if (k == rst_at) begin
          rst_n = 1'b0;
          cut_k = k;
          by_rst = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int s, t, ab;
    clear_faults();
    repeat (2) @(negedge clk);
    sel = 1'b0;
    #1 check_reset_values("reset a");
    sel = 1'b1;
    #1 check_reset_values("reset b");
    @(negedge clk);
    rst_all = 1'b1;

    run_sweep(1'b0, 0, 0, 1'b0, 1'b0);               // majority, all good
    fault[3] = 2'd1;
    fault[7] = 2'd1;
    run_sweep(1'b0, 0, 0, 1'b0, 1'b0);               // two failing vectors
    clear_faults();
    run_sweep(1'b1, 0, 0, 1'b0, 1'b0);               // half adder, SETTLE=3
    fault[1] = 2'd1;
    run_sweep(1'b0, 6, 0, 1'b0, 1'b0);               // abort at cycle 6
    clear_faults();
    run_sweep(1'b0, 0, 0, 1'b0, 1'b0);               // fresh sweep clears counts
    run_sweep(1'b0, 0, 0, 1'b1, 1'b0);               // mid-sweep starts ignored
    fault[2] = 2'd1;
    run_sweep(1'b0, 0, 10, 1'b0, 1'b0);              // reset at cycle 10
    clear_faults();
    run_sweep(1'b0, 0, 0, 1'b0, 1'b1);               // start+abort in IDLE: start wins

    for (int it = 0; it < 12; it++) begin
      s = $urandom_range(0, 1);
      t = (s != 0) ? 17 : 17;
      for (int v = 0; v < 8; v++) begin
        if ($urandom_range(0, 3) == 0) fault[v] = (s != 0) ? 2'($urandom_range(1, 3)) : 2'd1;
        else fault[v] = 2'd0;
      end
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, t - 1) : 0;
      run_sweep(s[0], ab, 0, (ab == 0) ? 1'($urandom_range(0, 1)) : 1'b0,
                1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
